// File: rtl/long_div_pipe_ctl.sv
// Radix-4 iterative signed/unsigned divider (DIV/DIVU/REM/REMU) with valid/ready handshakes.
// Magnitudes are divided with a restoring radix-4 loop, and signs are applied in the FIX state.
module long_div_pipe_ctl #(
    parameter int W       = 32,
    parameter bit EARLY_Z = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    input  logic         unsign_i,
    input  logic         kill_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] quot_o,
    output logic [W-1:0] remd_o,
    output logic         busy_o
);

    localparam int RW = W + 3;
    localparam int CW = $clog2(W / 2);
    localparam logic [CW-1:0] CNT_INIT = CW'(W / 2 - 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

    state_e        state_q;
    logic          in_ready_q, out_valid_q, busy_q;
    logic [W-1:0]  quot_q, remd_q;
    logic [RW-1:0] rem_q;
    logic [W-1:0]  dvd_q, dvs_q;
    logic [CW-1:0] cnt_q;
    logic          neg_q_q, neg_r_q;

    logic          dvd_neg_d, dvs_neg_d, div_zero_d, ovf_d;
    logic [W-1:0]  abs_dvd_d, abs_dvs_d, quot_fix_d, remd_fix_d;
    logic [RW-1:0] shifted_d, d1_d, d2_d, sub1_d, sub2_d, sub3_d;
    logic [RW-1:0] csa_sum_d, csa_maj_d, rem_d;
    logic [1:0]    digit_d;

    always_comb begin
        dvd_neg_d  = !unsign_i && dividend_i[W-1];
        dvs_neg_d  = !unsign_i && divisor_i[W-1];
        abs_dvd_d  = dvd_neg_d ? (~dividend_i + W'(1)) : dividend_i;
        abs_dvs_d  = dvs_neg_d ? (~divisor_i + W'(1)) : divisor_i;
        div_zero_d = (divisor_i == '0);
        ovf_d      = !unsign_i && (dividend_i == {1'b1, {(W-1){1'b0}}}) && (divisor_i == '1);

        // rem - 3d is formed as rem + ~d + ~2d + 2 through a 3:2 compressor
        shifted_d  = (rem_q << 2) | RW'(dvd_q[W-1:W-2]);
        d1_d       = {3'b000, dvs_q};
        d2_d       = {2'b00, dvs_q, 1'b0};
        sub1_d     = shifted_d - d1_d;
        sub2_d     = shifted_d - d2_d;
        csa_sum_d  = shifted_d ^ ~d1_d ^ ~d2_d;
        csa_maj_d  = (shifted_d & ~d1_d) | (shifted_d & ~d2_d) | (~d1_d & ~d2_d);
        sub3_d     = csa_sum_d + (csa_maj_d << 1) + RW'(2);

        digit_d = 2'd0;
        rem_d   = shifted_d;
        if (!sub3_d[RW-1]) begin
            digit_d = 2'd3;
            rem_d   = sub3_d;
        end else if (!sub2_d[RW-1]) begin
            digit_d = 2'd2;
            rem_d   = sub2_d;
        end else if (!sub1_d[RW-1]) begin
            digit_d = 2'd1;
            rem_d   = sub1_d;
        end

        quot_fix_d = neg_q_q ? (~dvd_q + W'(1)) : dvd_q;
        remd_fix_d = neg_r_q ? (~rem_q[W-1:0] + W'(1)) : rem_q[W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            quot_q      <= '0;
            remd_q      <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
        end else if (kill_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        // A zero divisor is never negated, so the quotient stays all ones
                        neg_q_q    <= (dvd_neg_d ^ dvs_neg_d) && !div_zero_d;
                        neg_r_q    <= dvd_neg_d;
                        dvd_q      <= abs_dvd_d;
                        dvs_q      <= abs_dvs_d;
                        rem_q      <= '0;
                        cnt_q      <= CNT_INIT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (EARLY_Z && (div_zero_d || ovf_d)) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            quot_q      <= div_zero_d ? '1 : dividend_i;
                            remd_q      <= div_zero_d ? dividend_i : '0;
                        end else begin
                            state_q <= ITER;
                        end
                    end
                end
                ITER: begin
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[W-3:0], digit_d};
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) state_q <= FIX;
                end
                FIX: begin
                    quot_q      <= quot_fix_d;
                    remd_q      <= remd_fix_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign quot_o      = quot_q;
    assign remd_o      = remd_q;

endmodule
